// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
//   arb_state_e : arbiter FSM states
//   owner_e     : which core port owns the current memory transaction
//   TIMEOUT_DEF : default read watchdog limit in WAIT cycles
//   CNT_W       : width of the watchdog counter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    localparam int TIMEOUT_DEF = 15;
    localparam int CNT_W       = 8;

endpackage

// File: rtl/mem_arb_timer.sv
// Read watchdog counter for the memory port arbiter.
//   clk   : system clock
//   rst   : synchronous active-high reset (count -> 0)
//   clr_i : clear count to 0 (has priority over en_i)
//   en_i  : increment count by one
//   tc_o  : count has reached TIMEOUT-1
module mem_arb_timer
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported, variable-latency memory between the core's
// instruction-fetch port (i_*) and load/store port (d_*). One transaction is
// outstanding at a time; a watchdog completes hung reads with bus_err.
//
// Optional build macro ARB_RR_EN: round-robin tie-break instead of fixed
// data priority.
//
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   i_req/i_addr              : fetch request, held until i_ack
//   i_ack/i_rdata             : fetch completion pulse and instruction
//   d_req/d_we/d_addr/d_wdata : data request, held until d_ack
//   d_ack/d_rdata             : data completion pulse and load data
//   mem_req/mem_we/mem_addr/mem_wdata : memory request, held until mem_gnt
//   mem_gnt                   : memory accepts request
//   mem_rvalid/mem_rdata      : memory read return
//   bus_err                   : pulse with the ack of a timed-out read
//
// FSM:
//   state | meaning
//   IDLE  | arbitrate between i_req and d_req
//   REQ   | mem_req held until mem_gnt
//   WAIT  | read granted, waiting for mem_rvalid or watchdog
//   DONE  | owner ack pulse, requests not sampled
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              bus_err
);

    arb_state_e        state_q, state_d;
    owner_e            owner_q, owner_d;
    owner_e            pick;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              i_ack_q, i_ack_d;
    logic              d_ack_q, d_ack_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              bus_err_q, bus_err_d;
    logic              tmr_clr, tmr_en, tmr_tc;
`ifdef ARB_RR_EN
    owner_e            last_q, last_d;
`endif

    mem_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr_i (tmr_clr),
        .en_i  (tmr_en),
        .tc_o  (tmr_tc)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_ack_d     = 1'b0;
        d_ack_d     = 1'b0;
        bus_err_d   = 1'b0;
        tmr_clr     = 1'b0;
        tmr_en      = 1'b0;
        pick        = OWN_D;
`ifdef ARB_RR_EN
        last_d      = last_q;
`endif

`ifdef ARB_RR_EN
        if (d_req && i_req) begin
            if (last_q == OWN_D) pick = OWN_I;
            else                 pick = OWN_D;
        end else if (d_req) begin
            pick = OWN_D;
        end else begin
            pick = OWN_I;
        end
`else
        if (d_req) pick = OWN_D;
        else       pick = OWN_I;
`endif

        case (state_q)
            IDLE: begin
                if (d_req || i_req) begin
                    owner_d   = pick;
                    mem_req_d = 1'b1;
                    state_d   = REQ;
`ifdef ARB_RR_EN
                    last_d    = pick;
`endif
                    if (pick == OWN_D) begin
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = i_addr;
                        mem_wdata_d = '0;
                    end
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    mem_req_d = 1'b0;
                    if (mem_we_q) begin
                        // Writes complete on grant; no read return expected.
                        state_d = DONE;
                        d_ack_d = (owner_q == OWN_D);
                        i_ack_d = (owner_q == OWN_I);
                    end else begin
                        tmr_clr = 1'b1;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                // rvalid beats the watchdog when both land in the same cycle.
                if (mem_rvalid || tmr_tc) begin
                    state_d   = DONE;
                    bus_err_d = !mem_rvalid;
                    if (owner_q == OWN_D) begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = mem_rvalid ? mem_rdata : '0;
                    end else begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = mem_rvalid ? mem_rdata : '0;
                    end
                end else begin
                    tmr_en = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_D;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            bus_err_q   <= 1'b0;
`ifdef ARB_RR_EN
            last_q      <= OWN_D;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_ack_q     <= i_ack_d;
            d_ack_q     <= d_ack_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            bus_err_q   <= bus_err_d;
`ifdef ARB_RR_EN
            last_q      <= last_d;
`endif
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_ack     = i_ack_q;
    assign d_ack     = d_ack_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (default parameters).
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        bus_err;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_ack      (i_ack),
        .i_rdata    (i_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_ack      (d_ack),
        .d_rdata    (d_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .bus_err    (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Called in the IDLE cycle where the request(s) are already driven.
    // Zero-wait read: mem_req at t+1 with gnt, rvalid at t+2, ack at t+3.
    // Returns in the DONE cycle with the owner's request dropped.
    task automatic read_txn(input string tag, input logic own_d,
                            input logic [31:0] exp_addr, input logic [31:0] rd);
        tick();
        chk1 ({tag, "_mem_req"}, mem_req, 1'b1);
        chk32({tag, "_mem_addr"}, mem_addr, exp_addr);
        chk1 ({tag, "_mem_we"}, mem_we, 1'b0);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        chk1 ({tag, "_req_drop"}, mem_req, 1'b0);
        chk1 ({tag, "_no_early_ack"}, i_ack | d_ack, 1'b0);
        mem_rvalid = 1'b1;
        mem_rdata  = rd;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        chk1 ({tag, "_i_ack"}, i_ack, !own_d);
        chk1 ({tag, "_d_ack"}, d_ack, own_d);
        chk32({tag, "_rdata"}, own_d ? d_rdata : i_rdata, rd);
        chk1 ({tag, "_bus_err"}, bus_err, 1'b0);
        if (own_d) d_req = 1'b0;
        else       i_req = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        i_req      = 1'b0;
        i_addr     = 32'h0;
        d_req      = 1'b0;
        d_we       = 1'b0;
        d_addr     = 32'h0;
        d_wdata    = 32'h0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        tick();
        tick();

        // reset state
        chk1 ("rst_mem_req", mem_req, 1'b0);
        chk1 ("rst_mem_we", mem_we, 1'b0);
        chk32("rst_mem_addr", mem_addr, 32'h0);
        chk1 ("rst_i_ack", i_ack, 1'b0);
        chk1 ("rst_d_ack", d_ack, 1'b0);
        chk32("rst_i_rdata", i_rdata, 32'h0);
        chk32("rst_d_rdata", d_rdata, 32'h0);
        chk1 ("rst_bus_err", bus_err, 1'b0);
        rst = 1'b0;
        tick();

        // simultaneous fetch (0x20) and load (0x80), first tie after reset
        i_req  = 1'b1;
        i_addr = 32'h20;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h80;
`ifdef ARB_RR_EN
        read_txn("tie1", 1'b0, 32'h20, 32'hAAAA0001);
        tick();
        read_txn("tie2", 1'b1, 32'h80, 32'hBBBB0002);
`else
        read_txn("tie1", 1'b1, 32'h80, 32'hAAAA0001);
        tick();
        read_txn("tie2", 1'b0, 32'h20, 32'hBBBB0002);
`endif
        tick();
        chk1("tie_ack_single", i_ack | d_ack, 1'b0);

        // fetch read, zero-wait memory
        i_req  = 1'b1;
        i_addr = 32'h10;
        read_txn("fetch", 1'b0, 32'h10, 32'h00500093);
        tick();
        chk1 ("fetch_ack_pulse", i_ack, 1'b0);
        chk32("fetch_rdata_hold", i_rdata, 32'h00500093);

        // store with grant delayed 3 cycles
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h44;
        d_wdata = 32'hDEADBEEF;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk1 ($sformatf("st_req_%0d", k), mem_req, 1'b1);
            chk1 ($sformatf("st_we_%0d", k), mem_we, 1'b1);
            chk32($sformatf("st_addr_%0d", k), mem_addr, 32'h44);
            chk32($sformatf("st_wdata_%0d", k), mem_wdata, 32'hDEADBEEF);
            chk1 ($sformatf("st_noack_%0d", k), d_ack, 1'b0);
            if (k == 3) mem_gnt = 1'b1;
        end
        tick();
        mem_gnt = 1'b0;
        chk1 ("st_d_ack", d_ack, 1'b1);
        chk1 ("st_i_ack", i_ack, 1'b0);
        chk1 ("st_req_drop", mem_req, 1'b0);
        chk1 ("st_bus_err", bus_err, 1'b0);
`ifdef ARB_RR_EN
        chk32("st_d_rdata_hold", d_rdata, 32'hBBBB0002);
`else
        chk32("st_d_rdata_hold", d_rdata, 32'hAAAA0001);
`endif
        d_req = 1'b0;
        d_we  = 1'b0;
        tick();
        chk1("st_ack_pulse", d_ack, 1'b0);

        // read timeout: 15 WAIT cycles then ack + bus_err
        i_req  = 1'b1;
        i_addr = 32'h30;
        tick();
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        for (int n = 1; n <= 15; n++) begin
            chk1($sformatf("to_wait_ack_%0d", n), i_ack, 1'b0);
            chk1($sformatf("to_wait_err_%0d", n), bus_err, 1'b0);
            tick();
        end
        chk1 ("to_i_ack", i_ack, 1'b1);
        chk1 ("to_bus_err", bus_err, 1'b1);
        chk32("to_i_rdata", i_rdata, 32'h0);
        chk1 ("to_d_ack", d_ack, 1'b0);
        i_req = 1'b0;
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000FFFF;
        chk1("to_err_pulse", bus_err, 1'b0);
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        chk1 ("late_i_ack", i_ack, 1'b0);
        chk1 ("late_d_ack", d_ack, 1'b0);
        chk32("late_i_rdata", i_rdata, 32'h0);
        chk1 ("late_mem_req", mem_req, 1'b0);

        // rvalid on the terminal-count cycle wins
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h50;
        tick();
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        repeat (14) tick();
        chk1("tc_not_yet", d_ack, 1'b0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h12345678;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        chk1 ("tc_d_ack", d_ack, 1'b1);
        chk1 ("tc_bus_err", bus_err, 1'b0);
        chk32("tc_d_rdata", d_rdata, 32'h12345678);
        d_req = 1'b0;
        tick();

        // reset while in WAIT
        i_req  = 1'b1;
        i_addr = 32'h60;
        tick();
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        rst     = 1'b1;
        i_req   = 1'b0;
        tick();
        chk1 ("rw_mem_req", mem_req, 1'b0);
        chk32("rw_mem_addr", mem_addr, 32'h0);
        chk1 ("rw_i_ack", i_ack, 1'b0);
        chk1 ("rw_bus_err", bus_err, 1'b0);
        chk32("rw_i_rdata", i_rdata, 32'h0);
        chk32("rw_d_rdata", d_rdata, 32'h0);
        rst = 1'b0;
        for (int n = 0; n < 20; n++) begin
            tick();
            chk1($sformatf("rw_no_ack_%0d", n), i_ack | d_ack | bus_err, 1'b0);
        end

        // fresh request after reset
        i_req  = 1'b1;
        i_addr = 32'h64;
        read_txn("post_rst", 1'b0, 32'h64, 32'h0000CAFE);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
